nms_ctrl: RTL

NMS_CTRL -- requirements
Module: nms_ctrl

---
 rtl/nms_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/nms_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nms_ctrl
// Purpose  : Full-frame 3x3 non-maximum-suppression sequencer. On a start
//            pulse it walks every non-border pixel of a COLUMNS x ROWS score
//            image in raster order. For each pixel it issues the centre and
//            its 8 neighbours to an external address calculator. It compares
//            the returned scores and pulses corner_valid for each pixel that
//            is a strict local maximum with a non-zero score.
//
// Ports    : clk          - single clock, all state on the rising edge
//            reset_n      - asynchronous active-low reset
//            start        - one-cycle pulse, starts a pass (ignored when busy
//                           or during the done cycle)
//            ref_addr     - reference address, centre = ref_addr - (COLUMNS+2)
//            adj_number   - 0 = centre, 1..8 = neighbour, 15 = idle select
//            score_data   - score read data, valid one cycle after the
//                           ref_addr/adj_number pair that requested it
//            corner_valid - one-cycle pulse, pixel at corner_addr survives
//            corner_addr  - centre address of the surviving pixel (held)
//            busy         - high from the first issue cycle until done
//            done         - one-cycle pulse at the end of the pass
//
// Config   : NMS_PLATEAU_TIEBREAK_EN (optional define)
//            Undefined : the centre must be strictly greater than all 8
//                        neighbours.
//            Defined   : the centre must be > neighbours 1..4 and >=
//                        neighbours 5..8. The address calculator numbers
//                        raster-later neighbours (E, SW, S, SE) 1..4 and
//                        raster-earlier ones (NW, N, NE, W) 5..8, so the
//                        later pixel of an equal pair survives.
//
// Revision : 1.0 - initial release
// ============================================================================
module nms_ctrl #(
  parameter int COLUMNS = 180,
  parameter int ROWS    = 120,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic [14:0]        ref_addr,
  output logic [3:0]         adj_number,
  input  logic [SCORE_W-1:0] score_data,
  output logic               corner_valid,
  output logic [14:0]        corner_addr,
  output logic               busy,
  output logic               done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int COL_W = (COLUMNS > 2) ? $clog2(COLUMNS) : 1;

  // ref_addr runs COLUMNS+2 ahead of the centre pixel it describes
  localparam logic [14:0]      c_centerOfs = 15'(COLUMNS + 2);
  // first centre is (row 1, col 1) = COLUMNS+1
  localparam logic [14:0]      c_firstRef  = 15'(2 * COLUMNS + 3);
  // last centre is (ROWS-2)*COLUMNS + COLUMNS-2
  localparam logic [14:0]      c_lastRef   = 15'(ROWS * COLUMNS);
  // skipping the right border, the left border and landing on col 1
  localparam logic [14:0]      c_rowStep   = 15'd3;
  localparam logic [14:0]      c_pixStep   = 15'd1;
  localparam logic [COL_W-1:0] c_firstCol  = COL_W'(1);
  localparam logic [COL_W-1:0] c_lastCol   = COL_W'(COLUMNS - 2);
  localparam logic [3:0]       c_adjCenter = 4'd0;
  localparam logic [3:0]       c_adjFirst  = 4'd1;
  localparam logic [3:0]       c_adjLast   = 4'd8;
  localparam logic [3:0]       c_adjIdle   = 4'd15;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t             r_state;
  logic [14:0]        r_ref;
  logic [3:0]         r_adj;
  logic [COL_W-1:0]   r_col;
  logic [SCORE_W-1:0] r_centerScore;
  logic               r_pass;
  logic               r_cornerValid;
  logic [14:0]        r_cornerAddr;
  logic               r_busy;
  logic               r_done;

  // --------------------------------------------------------------------------
  // Neighbour comparison
  // score_data returns the value requested one cycle earlier. During ISSUE
  // that is neighbour r_adj-1. During EVAL it is neighbour 8.
  // --------------------------------------------------------------------------
  logic w_beats;
  logic w_survive;

`ifdef NMS_PLATEAU_TIEBREAK_EN
  logic [3:0] w_nbIdx;

  assign w_nbIdx = (r_state == S_EVAL) ? c_adjLast : (r_adj - 4'd1);
  assign w_beats = (w_nbIdx >= 4'd5) ? (r_centerScore >= score_data)
                                     : (r_centerScore >  score_data);
`else
  assign w_beats = (r_centerScore > score_data);
`endif

  // Final verdict, taken while neighbour 8 is on score_data
  assign w_survive = r_pass & w_beats;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ref         <= '0;
      r_adj         <= c_adjIdle;
      r_col         <= '0;
      r_centerScore <= '0;
      r_pass        <= 1'b0;
      r_cornerValid <= 1'b0;
      r_cornerAddr  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // single-cycle pulses
      r_cornerValid <= 1'b0;
      r_done        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_adj <= c_adjIdle;
          // r_done is high only in the cycle right after a pass; a start
          // seen then is dropped
          if (start && !r_done) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_ref   <= c_firstRef;
            r_col   <= c_firstCol;
            r_adj   <= c_adjCenter;
          end
        end

        S_ISSUE: begin
          if (r_adj == c_adjFirst) begin
            // centre score arrives now; a zero centre can never survive
            r_centerScore <= score_data;
            r_pass        <= |score_data;
          end else if (r_adj != c_adjCenter && !w_beats) begin
            r_pass <= 1'b0;
          end

          if (r_adj == c_adjLast) begin
            r_state <= S_EVAL;
          end else begin
            r_adj <= r_adj + 4'd1;
          end
        end

        S_EVAL: begin
          if (w_survive) begin
            r_cornerValid <= 1'b1;
            r_cornerAddr  <= r_ref - c_centerOfs;
          end

          if (r_ref == c_lastRef) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_adj   <= c_adjIdle;
          end else begin
            r_state <= S_ISSUE;
            r_adj   <= c_adjCenter;
            if (r_col == c_lastCol) begin
              r_ref <= r_ref + c_rowStep;
              r_col <= c_firstCol;
            end else begin
              r_ref <= r_ref + c_pixStep;
              r_col <= r_col + c_firstCol;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_adj   <= c_adjIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ref_addr     = r_ref;
  assign adj_number   = r_adj;
  assign corner_valid = r_cornerValid;
  assign corner_addr  = r_cornerAddr;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire
